// File: rtl/lw_sha_ctx_engine.sv
// lw_sha_ctx_engine: multi-context SHA-256/224 compression, one round per clock.
// Define LW_SHA_WIPE_EN to zero context/working/schedule state on abort and final block.
module lw_sha_ctx_engine #(
  parameter int NUM_CTX = 4,
  localparam int CTX_W = ($clog2(NUM_CTX) > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic                 start_i,
  input  logic                 opcode_i,
  input  logic [CTX_W-1:0]     ctx_i,
  input  logic                 last_i,
  input  logic                 data_valid_i,
  input  logic [31:0]          data_i,
  input  logic                 abort_i,
  output logic                 ready_o,
  output logic                 core_ready_o,
  output logic [7:0][31:0]     hash_o,
  output logic [CTX_W-1:0]     hash_ctx_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [NUM_CTX-1:0]   ctx_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_EXPAND, S_FINAL
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [7:0][31:0] iv(input logic op);
    if (op)
      return {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
              32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    return {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  endfunction

  function automatic logic [31:0] bs0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bs1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // word [7] is a ... word [0] is h
  function automatic logic [7:0][31:0] rnd(
    input logic [7:0][31:0] s,
    input logic [31:0]      k,
    input logic [31:0]      w
  );
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = s[0] + bs1(s[3]) + ((s[3] & s[2]) ^ (~s[3] & s[1])) + k + w;
    t2 = bs0(s[7]) + ((s[7] & s[6]) ^ (s[7] & s[5]) ^ (s[6] & s[5]));
    return {t1 + t2, s[7], s[6], s[5], s[4] + t1, s[3], s[2], s[1]};
  endfunction

  state_t              r_state;
  state_t              w_state_nx;
  logic                r_rdy;
  logic [5:0]          r_round;
  logic [CTX_W-1:0]    r_ctx;
  logic                r_start;
  logic                r_op;
  logic                r_last;
  logic                r_done;
  logic                r_err;
  logic [NUM_CTX-1:0]  r_busy;
  logic [NUM_CTX-1:0]  r_ctx_op;
  logic [7:0][31:0]    r_work;
  logic [15:0][31:0]   r_ring;
  logic [7:0][31:0]    r_store [NUM_CTX];
  logic [7:0][31:0]    r_hash;
  logic [CTX_W-1:0]    r_hctx;

  logic                w_idle;
  logic                w_acc0;
  logic                w_err;
  logic                w_abort;
  logic                w_adv;
  logic [5:0]          w_rid;
  logic [3:0]          w_i0;
  logic [3:0]          w_i1;
  logic [3:0]          w_i9;
  logic [3:0]          w_i14;
  logic [31:0]         w_wexp;
  logic [31:0]         w_w;
  logic [7:0][31:0]    w_src;
  logic [7:0][31:0]    w_next;
  logic [7:0][31:0]    w_chain;
  logic [7:0][31:0]    w_sum;

  assign w_idle  = (r_state == S_IDLE);
  assign w_acc0  = w_idle && r_rdy && data_valid_i && !abort_i
                   && (start_i || r_busy[ctx_i]);
  assign w_err   = w_idle && r_rdy && data_valid_i && !abort_i
                   && !start_i && !r_busy[ctx_i];
  assign w_abort = abort_i && (r_state == S_LOAD || r_state == S_EXPAND);
  assign w_adv   = w_acc0
                   || (r_state == S_LOAD && data_valid_i && !abort_i)
                   || (r_state == S_EXPAND && !abort_i);

  assign w_rid  = w_idle ? 6'd0 : r_round;
  assign w_i0   = r_round[3:0];
  assign w_i1   = w_i0 + 4'd1;
  assign w_i9   = w_i0 + 4'd9;
  assign w_i14  = w_i0 + 4'd14;
  assign w_wexp = ss1(r_ring[w_i14]) + r_ring[w_i9]
                  + ss0(r_ring[w_i1]) + r_ring[w_i0];
  assign w_w    = (r_state == S_EXPAND) ? w_wexp : data_i;

  // word 0 starts from IV or the stored chaining value directly
  assign w_src   = w_idle ? (start_i ? iv(opcode_i) : r_store[ctx_i])
                          : r_work;
  assign w_next  = rnd(w_src, K[w_rid], w_w);
  assign w_chain = r_start ? iv(r_op) : r_store[r_ctx];

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++)
      w_sum[i] = w_chain[i] + r_work[i];
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) r_state <= S_IDLE;
    else            r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_acc0) w_state_nx = S_LOAD;
      S_LOAD:
        if (abort_i)
          w_state_nx = S_IDLE;
        else if (data_valid_i && r_round == 6'd15)
          w_state_nx = S_EXPAND;
      S_EXPAND:
        if (abort_i)
          w_state_nx = S_IDLE;
        else if (r_round == 6'd63)
          w_state_nx = S_FINAL;
      S_FINAL:
        w_state_nx = S_IDLE;
      default:
        w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_rdy    <= 1'b0;
      r_round  <= '0;
      r_ctx    <= '0;
      r_start  <= 1'b0;
      r_op     <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= '0;
      r_ctx_op <= '0;
      r_work   <= '0;
      r_ring   <= '0;
      r_hash   <= '0;
      r_hctx   <= '0;
      for (int i = 0; i < NUM_CTX; i++)
        r_store[i] <= '0;
    end else begin
      r_rdy  <= 1'b1;
      r_done <= 1'b0;
      r_err  <= w_err;
      if (w_acc0) begin
        r_ctx   <= ctx_i;
        r_start <= start_i;
        r_last  <= last_i;
        r_op    <= start_i ? opcode_i : r_ctx_op[ctx_i];
        if (start_i) r_ctx_op[ctx_i] <= opcode_i;
      end else if (r_state == S_LOAD && data_valid_i && !abort_i) begin
        r_last <= r_last | last_i;
      end
      if (w_adv) begin
        r_work         <= w_next;
        r_ring[w_rid[3:0]] <= w_w;
        r_round        <= w_rid + 6'd1;
      end
      if (w_abort) begin
        r_busy[r_ctx] <= 1'b0;
        r_round       <= '0;
`ifdef LW_SHA_WIPE_EN
        r_store[r_ctx] <= '0;
        r_work         <= '0;
        r_ring         <= '0;
`endif
      end
      if (r_state == S_FINAL) begin
        r_round <= '0;
        if (r_last) begin
          r_busy[r_ctx] <= 1'b0;
          r_done        <= 1'b1;
          r_hctx        <= r_ctx;
          r_hash        <= w_sum;
          if (r_op) r_hash[0] <= '0;
`ifdef LW_SHA_WIPE_EN
          r_store[r_ctx] <= '0;
          r_work         <= '0;
          r_ring         <= '0;
`else
          r_store[r_ctx] <= w_sum;
`endif
        end else begin
          r_busy[r_ctx]  <= 1'b1;
          r_store[r_ctx] <= w_sum;
        end
      end
    end
  end

  assign ready_o      = r_rdy && (r_state == S_IDLE || r_state == S_LOAD);
  assign core_ready_o = r_rdy && w_idle;
  assign hash_o       = r_hash;
  assign hash_ctx_o   = r_hctx;
  assign done_o       = r_done;
  assign error_o      = r_err;
  assign ctx_busy_o   = r_busy;

endmodule

// File: tb/tb_lw_sha_ctx_engine.sv
// tb_lw_sha_ctx_engine: directed checks of lw_sha_ctx_engine.
// Known SHA-256/224 vectors, interleaving, error, abort, stall and reset.
module tb_lw_sha_ctx_engine;

  logic             clk;
  logic             aresetn;
  logic             start;
  logic             opcode;
  logic [1:0]       ctx;
  logic             last;
  logic             data_valid;
  logic [31:0]      data;
  logic             abort;
  logic             ready_o;
  logic             core_ready_o;
  logic [7:0][31:0] hash_o;
  logic [1:0]       hash_ctx_o;
  logic             done_o;
  logic             error_o;
  logic [3:0]       ctx_busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int lat;
  logic seen;

  logic [31:0] abc [16];
  logic [31:0] m1  [16];
  logic [31:0] m2  [16];

  localparam logic [255:0] D_ABC256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_ABC224 =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] D_448 =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  lw_sha_ctx_engine #(.NUM_CTX(4)) dut (
    .clk_i        (clk),
    .aresetn_i    (aresetn),
    .start_i      (start),
    .opcode_i     (opcode),
    .ctx_i        (ctx),
    .last_i       (last),
    .data_valid_i (data_valid),
    .data_i       (data),
    .abort_i      (abort),
    .ready_o      (ready_o),
    .core_ready_o (core_ready_o),
    .hash_o       (hash_o),
    .hash_ctx_o   (hash_ctx_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .ctx_busy_o   (ctx_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!core_ready_o && n < 300) begin
      tick();
      n++;
    end
    chk("idle_wait", 256'(core_ready_o), 256'(1));
  endtask

  task automatic send_blk(input logic [1:0] c, input logic st,
                          input logic op, input logic lst,
                          input logic [31:0] blk [16], input int stall_at);
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        data_valid = 1'b0;
        repeat (3) tick();
      end
      data_valid = 1'b1;
      data   = blk[i];
      ctx    = c;
      start  = st;
      opcode = op;
      last   = lst;
      tick();
      if (i == 0) c0 = cyc;
    end
    data_valid = 1'b0;
    start = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 300) begin
      tick();
      n++;
    end
    lat = cyc - c0;
    chk("done_seen", 256'(done_o), 256'(1));
  endtask

  initial begin
    abc = '{default: 32'h0};
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;
    m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
           32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
           32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
           32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    m2 = '{default: 32'h0};
    m2[15] = 32'h000001c0;

    aresetn = 1'b0;
    start = 1'b0;
    opcode = 1'b0;
    ctx = 2'd0;
    last = 1'b0;
    data_valid = 1'b0;
    data = 32'h0;
    abort = 1'b0;
    repeat (3) tick();
    chk("rst_ctl", 256'({ready_o, core_ready_o, done_o, error_o,
                         hash_ctx_o, ctx_busy_o}), 256'(0));
    chk("rst_hash", 256'(hash_o), 256'(0));
    aresetn = 1'b1;
    #1;
    chk("rst_first_cycle", 256'(core_ready_o), 256'(0));
    tick();
    chk("rst_then_ready", 256'(core_ready_o), 256'(1));

    // SHA-256 "abc"
    send_blk(2'd0, 1'b1, 1'b0, 1'b1, abc, -1);
    wait_done();
    chk("t1_latency", 256'(lat), 256'(64));
    chk("t1_digest", 256'(hash_o), D_ABC256);
    chk("t1_ctx", 256'(hash_ctx_o), 256'(0));
    chk("t1_busy", 256'(ctx_busy_o), 256'(0));
    chk("t1_core_ready", 256'(core_ready_o), 256'(1));
    tick();
    chk("t1_done_pulse", 256'(done_o), 256'(0));
    chk("t1_hold", 256'(hash_o), D_ABC256);

    // SHA-224 "abc" on ctx3
    send_blk(2'd3, 1'b1, 1'b1, 1'b1, abc, -1);
    wait_done();
    chk("t2_digest", 256'(hash_o), D_ABC224);
    chk("t2_ctx", 256'(hash_ctx_o), 256'(3));

    // interleaved contexts
    send_blk(2'd0, 1'b1, 1'b0, 1'b0, m1, -1);
    wait_idle();
    chk("t3_blk1_no_done", 256'(done_o), 256'(0));
    chk("t3_busy_mid", 256'(ctx_busy_o), 256'(1));
    send_blk(2'd1, 1'b1, 1'b0, 1'b1, abc, -1);
    wait_done();
    chk("t3_ctx1_digest", 256'(hash_o), D_ABC256);
    chk("t3_ctx1_id", 256'(hash_ctx_o), 256'(1));
    chk("t3_busy_keep", 256'(ctx_busy_o), 256'(1));
    send_blk(2'd0, 1'b0, 1'b0, 1'b1, m2, -1);
    wait_done();
    chk("t3_ctx0_digest", 256'(hash_o), D_448);
    chk("t3_ctx0_id", 256'(hash_ctx_o), 256'(0));
    chk("t3_busy_end", 256'(ctx_busy_o), 256'(0));

    // continuation on an idle context
    tick();
    data_valid = 1'b1;
    start = 1'b0;
    ctx = 2'd2;
    data = 32'h12345678;
    tick();
    data_valid = 1'b0;
    chk("t4_error", 256'(error_o), 256'(1));
    chk("t4_idle", 256'({core_ready_o, done_o}), 256'(2));
    tick();
    chk("t4_error_pulse", 256'(error_o), 256'(0));

    // abort together with word 0
    data_valid = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    data_valid = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    chk("t5_abort_w0", 256'(core_ready_o), 256'(1));

    // abort at round 30 of a continuation block
    send_blk(2'd0, 1'b1, 1'b0, 1'b0, m1, -1);
    wait_idle();
    chk("t5_busy_set", 256'(ctx_busy_o), 256'(1));
    send_blk(2'd0, 1'b0, 1'b0, 1'b1, m2, -1);
    repeat (14) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_idle", 256'(core_ready_o), 256'(1));
    chk("t5_abort_busy", 256'(ctx_busy_o), 256'(0));
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      seen = seen | done_o;
      tick();
    end
    chk("t5_no_done", 256'(seen), 256'(0));
    data_valid = 1'b1;
    start = 1'b0;
    ctx = 2'd0;
    tick();
    data_valid = 1'b0;
    chk("t5_ctx0_closed", 256'(error_o), 256'(1));
    send_blk(2'd0, 1'b1, 1'b0, 1'b1, abc, -1);
    wait_done();
    chk("t5_rerun", 256'(hash_o), D_ABC256);

    // input stall at round 7
    send_blk(2'd2, 1'b1, 1'b0, 1'b1, abc, 7);
    wait_done();
    chk("t6_stall_lat", 256'(lat), 256'(67));
    chk("t6_stall_dig", 256'(hash_o), D_ABC256);

    // reset at round 40
    send_blk(2'd0, 1'b1, 1'b0, 1'b0, m1, -1);
    repeat (24) tick();
    aresetn = 1'b0;
    #2;
    chk("t6_rst_ctl", 256'({ready_o, core_ready_o, done_o, error_o,
                            hash_ctx_o, ctx_busy_o}), 256'(0));
    chk("t6_rst_hash", 256'(hash_o), 256'(0));
    tick();
    aresetn = 1'b1;
    send_blk(2'd1, 1'b1, 1'b0, 1'b1, abc, -1);
    wait_done();
    chk("t6_after_rst", 256'(hash_o), D_ABC256);
    chk("t6_busy_after", 256'(ctx_busy_o), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
